rggen_bit_field_wfifo: RTL and testbench

Software-to-hardware queued bit field: each register write pushes the masked write data into a DEPTH-entry FIFO. Hardware drains the FIFO over a valid/ready handshake. It is the producer/consumer counterpart of the read-to-clear field, where hardware produces and software consumes. It sits in the register block beside the other `rggen_bit_field_*` cells and connects through `rggen_bit_field_if`.

---
 rtl/rggen_bit_field_wfifo_if.sv | 39 +++
 rtl/rggen_bit_field_wfifo.sv | 88 ++++++++
 tb/tb_rggen_bit_field_wfifo.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rggen_bit_field_wfifo_if.sv
// Register-side access bundle shared by the rggen_bit_field_* cells.
// The bit_field/slave modports face the field cell; master faces the register block.
interface rggen_bit_field_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic [WIDTH-1:0] read_mask;
  logic [WIDTH-1:0] write_mask;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] read_data;
  logic [WIDTH-1:0] value;

  modport bit_field (
    input  valid,
    input  read_mask,
    input  write_mask,
    input  write_data,
    output read_data,
    output value
  );

  modport slave (
    input  valid,
    input  read_mask,
    input  write_mask,
    input  write_data,
    output read_data,
    output value
  );

  modport master (
    output valid,
    output read_mask,
    output write_mask,
    output write_data,
    input  read_data,
    input  value
  );
endinterface

// File: rtl/rggen_bit_field_wfifo.sv
// Software-to-hardware queued bit field: register writes push masked data into a
// DEPTH-entry FIFO that hardware drains over a valid/ready handshake.
module rggen_bit_field_wfifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  rggen_bit_field_if.bit_field      bit_field_if,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [WIDTH-1:0]          o_data,
  output logic [CW-1:0]             o_count,
  output logic                      o_full,
  output logic                      o_overflow
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;

  logic             push_req;
  logic             pop;
  logic             push_ok;
  logic [WIDTH-1:0] push_data;

  assign push_req  = bit_field_if.valid && (|bit_field_if.write_mask);
  assign push_data = bit_field_if.write_data & bit_field_if.write_mask;
  assign pop       = (count_q != '0) && i_ready;
  // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
  assign push_ok   = push_req && ((count_q < CW'(DEPTH)) || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = push_req && !push_ok;
    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign o_valid    = (count_q != '0);
  assign o_data     = mem_q[rd_ptr_q];
  assign o_count    = count_q;
  assign o_full     = (count_q == CW'(DEPTH));
  assign o_overflow = overflow_q;

  assign bit_field_if.read_data = o_valid ? (o_data & bit_field_if.read_mask) : '0;
  assign bit_field_if.value     = o_data;

endmodule

// File: tb/tb_rggen_bit_field_wfifo.sv
// Scoreboard bench for rggen_bit_field_wfifo: expected words are queued when
// writes are driven and compared when hardware pops them.
module tb_rggen_bit_field_wfifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst_n;
  logic             ready;
  logic             o_valid;
  logic [WIDTH-1:0] o_data;
  logic [CW-1:0]    o_count;
  logic             o_full;
  logic             o_overflow;

  int checks;
  int errors;
  logic [WIDTH-1:0] sb [$];

  rggen_bit_field_if #(.WIDTH(WIDTH)) bif ();

  rggen_bit_field_wfifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .bit_field_if (bif.bit_field),
    .o_valid      (o_valid),
    .i_ready      (ready),
    .o_data       (o_data),
    .o_count      (o_count),
    .o_full       (o_full),
    .o_overflow   (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after posedge, so negedge sees the values the next edge will use.
  always @(negedge clk) begin
    if (rst_n && o_valid && ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL pop_unexpected: o_data=%h popped but scoreboard empty", o_data);
      end else begin
        logic [WIDTH-1:0] exp;
        exp = sb.pop_front();
        if (o_data !== exp) begin
          errors++;
          $display("[TB] FAIL pop_data: got %h expected %h", o_data, exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] data, input logic [WIDTH-1:0] mask,
                               input logic rdy);
    bif.valid      = 1'b1;
    bif.write_data = data;
    bif.write_mask = mask;
    bif.read_mask  = '0;
    ready          = rdy;
    tick();
    bif.valid      = 1'b0;
    bif.write_mask = '0;
    bif.write_data = '0;
    ready          = 1'b0;
  endtask

  task automatic drain(input int n);
    ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (o_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL drain_valid: cycle %0d o_valid=%b expected 1", i, o_valid);
      end
      tick();
    end
    ready = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_empty: o_valid=%b sb_left=%0d expected 0/0", o_valid, sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n          = 1'b1;
    ready          = 1'b1;
    bif.valid      = 1'b1;
    bif.read_mask  = 8'hFF;
    tick();
    checks++;
    if (o_count !== 0 || o_valid !== 0 || o_full !== 0 || o_overflow !== 0) begin
      errors++;
      $display("[TB] FAIL reset_flags: count=%0d valid=%b full=%b ovf=%b expected 0", o_count,
               o_valid, o_full, o_overflow);
    end
    checks++;
    if (o_data !== 8'h00 || bif.read_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_data: o_data=%h read_data=%h expected 00", o_data, bif.read_data);
    end
    tick();
    checks++;
    if (o_count !== 0 || o_valid !== 0) begin
      errors++;
      $display("[TB] FAIL idle_ready: count=%0d valid=%b expected 0", o_count, o_valid);
    end
    bif.valid     = 1'b0;
    bif.read_mask = '0;
    ready         = 1'b0;
  endtask

  task automatic test_masked_write();
    sb.push_back(8'h05);
    applyStimulus(8'hA5, 8'h0F, 1'b0);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h05 || o_count !== 1) begin
      errors++;
      $display("[TB] FAIL masked_write: valid=%b data=%h count=%0d expected 1/05/1", o_valid,
               o_data, o_count);
    end
    bif.valid     = 1'b1;
    bif.read_mask = 8'hFF;
    #1;
    checks++;
    if (bif.read_data !== 8'h05) begin
      errors++;
      $display("[TB] FAIL sw_read: read_data=%h expected 05", bif.read_data);
    end
    tick();
    bif.valid     = 1'b0;
    bif.read_mask = '0;
    checks++;
    if (o_count !== 1) begin
      errors++;
      $display("[TB] FAIL read_no_side_effect: count=%0d expected 1", o_count);
    end
    drain(1);
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 4; i++) begin
      sb.push_back(8'(i * 8'h11));
      applyStimulus(8'(i * 8'h11), 8'hFF, 1'b0);
    end
    checks++;
    if (o_full !== 1'b1 || o_count !== 4 || o_overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fill: full=%b count=%0d ovf=%b expected 1/4/0", o_full, o_count,
               o_overflow);
    end
    applyStimulus(8'h55, 8'hFF, 1'b0);
    checks++;
    if (o_overflow !== 1'b1 || o_count !== 4) begin
      errors++;
      $display("[TB] FAIL overflow_pulse: ovf=%b count=%0d expected 1/4", o_overflow, o_count);
    end
    tick();
    checks++;
    if (o_overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overflow_width: ovf=%b expected 0", o_overflow);
    end
    drain(4);
  endtask

  task automatic test_full_push_pop();
    for (int i = 1; i <= 4; i++) begin
      sb.push_back(8'(i * 8'h11));
      applyStimulus(8'(i * 8'h11), 8'hFF, 1'b0);
    end
    sb.push_back(8'h99);
    applyStimulus(8'h99, 8'hFF, 1'b1);
    checks++;
    if (o_overflow !== 1'b0 || o_count !== 4 || o_full !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_push_pop: ovf=%b count=%0d full=%b expected 0/4/1", o_overflow,
               o_count, o_full);
    end
    drain(4);
  endtask

  task automatic test_wrap();
    sb.push_back(8'd0);
    applyStimulus(8'd0, 8'hFF, 1'b0);
    for (int i = 1; i < 10; i++) begin
      sb.push_back(8'(i));
      applyStimulus(8'(i), 8'hFF, 1'b0);
      checks++;
      if (o_count !== 2) begin
        errors++;
        $display("[TB] FAIL wrap_push: step %0d count=%0d expected 2", i, o_count);
      end
      ready = 1'b1;
      tick();
      ready = 1'b0;
      checks++;
      if (o_count !== 1) begin
        errors++;
        $display("[TB] FAIL wrap_pop: step %0d count=%0d expected 1", i, o_count);
      end
    end
    drain(1);
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(8'(i + 8'h40), 8'hFF, 1'b0);
    end
    rst_n = 1'b0;
    ready = 1'b1;
    sb.delete();
    tick();
    rst_n = 1'b1;
    ready = 1'b0;
    checks++;
    if (o_count !== 0 || o_valid !== 0 || o_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_mid: count=%0d valid=%b data=%h expected 0/0/00", o_count,
               o_valid, o_data);
    end
    sb.push_back(8'h7E);
    applyStimulus(8'h7E, 8'hFF, 1'b0);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h7E) begin
      errors++;
      $display("[TB] FAIL post_reset_write: valid=%b data=%h expected 1/7e", o_valid, o_data);
    end
    drain(1);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    ready          = 1'b0;
    bif.valid      = 1'b0;
    bif.read_mask  = '0;
    bif.write_mask = '0;
    bif.write_data = '0;
    test_reset();
    test_masked_write();
    test_overflow();
    test_full_push_pop();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
